// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit two-operand bitwise logic unit with valid/ready handshake,
// streaming accumulate mode, reduction flags and a saturating accepted-beat counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             red_or,
  output logic             red_and,
  output logic             red_xor,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOT_X = 3'b110,
    OP_PASS  = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;
  logic [WIDTH-1:0] func_out;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             xfer;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // In accumulate mode the running value takes the X slot and the new A operand the Y slot.
  always_comb begin
    opnd_x = a;
    opnd_y = b;
    if (acc_en) begin
      opnd_x = acc;
      opnd_y = a;
    end
  end

  always_comb begin
    func_out = '0;
    unique case (op_e'(op))
      OP_AND:   func_out = opnd_x & opnd_y;
      OP_OR:    func_out = opnd_x | opnd_y;
      OP_XOR:   func_out = opnd_x ^ opnd_y;
      OP_NAND:  func_out = ~(opnd_x & opnd_y);
      OP_NOR:   func_out = ~(opnd_x | opnd_y);
      OP_XNOR:  func_out = ~(opnd_x ^ opnd_y);
      OP_NOT_X: func_out = ~opnd_x;
      OP_PASS:  func_out = opnd_x;
      default:  func_out = '0;
    endcase
  end

  always_comb begin
    result = func_out;
    if (acc_en && acc_clr) begin
      result = a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      red_or    <= 1'b0;
      red_and   <= 1'b0;
      red_xor   <= 1'b0;
      beat_cnt  <= '0;
      acc       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        y         <= result;
        red_or    <= |result;
        red_and   <= &result;
        red_xor   <= ^result;
        if (acc_en) begin
          acc <= result;
        end
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed self-checking bench for logic_unit_pipe against a
// transaction-level reference model (8-bit, 3-bit-counter and 1-bit instances).
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       acc_clr;
  logic       out_ready;

  logic       in_ready, out_valid, red_or, red_and, red_xor;
  logic [7:0] y;
  logic [7:0] beat_cnt;

  logic       in_ready3, out_valid3, red_or3, red_and3, red_xor3;
  logic [7:0] y3;
  logic [2:0] beat_cnt3;

  logic       in_ready1, out_valid1, red_or1, red_and1, red_xor1;
  logic [0:0] y1;
  logic [7:0] beat_cnt1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  logic       m_valid;
  logic [7:0] m_y;
  logic [7:0] m_acc;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .red_or(red_or), .red_and(red_and), .red_xor(red_xor), .beat_cnt(beat_cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid3), .out_ready(out_ready), .y(y3),
    .red_or(red_or3), .red_and(red_and3), .red_xor(red_xor3), .beat_cnt(beat_cnt3)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(8)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a[0:0]), .b(b[0:0]), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1),
    .red_or(red_or1), .red_and(red_and1), .red_xor(red_xor1), .beat_cnt(beat_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic iv, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [2:0] o, input logic ae, input logic ac, input logic ordy);
    logic       m_ready;
    logic       take;
    logic [7:0] res;
    @(negedge clk);
    rst = r; in_valid = iv; a = aa; b = bb; op = o;
    acc_en = ae; acc_clr = ac; out_ready = ordy;
    #1;
    m_ready = !m_valid || ordy;
    check("in_ready", 32'(in_ready), 32'(m_ready));
    take = iv && m_ready && !r;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_y = '0; m_acc = '0; m_cnt = 0;
    end else if (take) begin
      if (!ae)     res = ref_op(o, aa, bb);
      else if (ac) res = aa;
      else         res = ref_op(o, m_acc, aa);
      if (ae) m_acc = res;
      m_y = res;
      m_valid = 1'b1;
      m_cnt++;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("y", 32'(y), 32'(m_y));
    check("red_or", 32'(red_or), 32'(|m_y));
    check("red_and", 32'(red_and), 32'(&m_y));
    check("red_xor", 32'(red_xor), 32'(^m_y));
    check("beat_cnt", 32'(beat_cnt), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
    check("beat_cnt_w3", 32'(beat_cnt3), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
    check("y_w3", 32'(y3), 32'(m_y));
    check("y_w1", 32'(y1), 32'(m_y[0]));
    check("red_w1", 32'({red_or1, red_and1, red_xor1}), {29'd0, {3{m_y[0]}}});
  endtask

  initial begin
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_y = '0; m_acc = '0; m_cnt = 0;

    repeat (2) cycle(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
    cycle(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);

    // OR basic and truth-table sweep on bit 0
    cycle(0, 1, 8'h0F, 8'hF0, 3'd1, 0, 0, 1);
    pa = '{8'h00, 8'h00, 8'h01, 8'h01};
    pb = '{8'h00, 8'h01, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) cycle(0, 1, pa[i], pb[i], 3'd1, 0, 0, 1);

    // all ops on A5/3C
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'hA5, 8'h3C, 3'(i), 0, 0, 1);

    // backpressure: hold for 5 cycles, then release
    cycle(0, 1, 8'h11, 8'h22, 3'd2, 0, 0, 0);
    repeat (5) cycle(0, 1, 8'h33, 8'h44, 3'd0, 0, 0, 0);
    cycle(0, 1, 8'h33, 8'h44, 3'd0, 0, 0, 1);
    cycle(0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);

    // accumulate OR, then AND with clear
    cycle(0, 1, 8'h01, 8'h00, 3'd1, 1, 1, 1);
    cycle(0, 1, 8'h04, 8'h00, 3'd1, 1, 0, 1);
    cycle(0, 1, 8'h10, 8'h00, 3'd1, 1, 0, 1);
    cycle(0, 1, 8'hFF, 8'h00, 3'd0, 1, 1, 1);
    cycle(0, 1, 8'h0F, 8'h00, 3'd0, 1, 0, 1);

    // reset with pending output and a presented beat, then acc restarts from 0
    cycle(0, 1, 8'h5A, 8'h00, 3'd7, 0, 0, 0);
    cycle(1, 1, 8'h77, 8'h00, 3'd1, 1, 0, 0);
    cycle(0, 1, 8'h02, 8'h00, 3'd1, 1, 0, 1);

    // counter saturation on the 3-bit instance
    cycle(1, 0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'(i), 8'h0F, 3'd2, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 3'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's 2-input OR gate: a WIDTH-bit two-operand bitwise logic unit with 8 selectable operations, valid/ready handshaking and a 1-cycle output register.
- Adds a streaming accumulate mode (running fold of successive A operands) and reduction flags on the result.
- Sits in the combinational-designs area as the reusable registered gate primitive for datapath experiments and bench training.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 8, width of accepted-beat counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B (ignored in accumulate mode)
op  in  3  operation select, sampled with the beat
acc_en  in  1  accumulate mode for this beat
acc_clr  in  1  restart accumulation with this beat
out_valid  out  1  y holds a valid result
out_ready  in  1  downstream accepts result
y  out  WIDTH  registered result
red_or  out  1  |y, registered with y
red_and  out  1  &y, registered with y
red_xor  out  1  ^y, registered with y
beat_cnt  out  CNT_W  number of accepted input beats, saturating

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst. While rst=1 at a rising edge: out_valid=0, y=0, red_or=0, red_and=0, red_xor=0, beat_cnt=0, acc=0. in_ready reads 1 in the cycle after reset.
- Ops, applied as f(X,Y): 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT X, 111 pass X. All ops are bitwise across WIDTH.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept happens when in_valid && in_ready at a rising edge.
  - Transfer out happens when out_valid && out_ready.
- Latency: an accepted beat appears on y/out_valid in the next cycle. Full throughput is 1 beat/cycle while out_ready=1.
- Hold: while out_valid=1 and out_ready=0, y, the reduction flags and out_valid stay stable, and in_ready=0.
- Output register: on accept, out_valid<=1. On transfer with no accept, out_valid<=0. Simultaneous transfer and accept loads the new result with out_valid staying 1.
- Normal mode (acc_en=0): y<=f(a,b); acc is unchanged.
- Accumulate mode (acc_en=1), on an accepted beat:
  - acc_clr=1: result=a and acc<=a. acc_clr has priority over the fold.
  - acc_clr=0: result=f(acc,a) and acc<=result.
  - y<=result in both cases.
- acc_clr is ignored unless acc_en=1 and the beat is accepted.
- acc is internal and is not cleared by out_ready activity.
- Reductions are computed from the next y value and registered together with it, so they are always consistent with y.
- beat_cnt increments on each accept and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-operation: a pending output is dropped (out_valid=0), acc=0 and beat_cnt=0. An input presented in the same cycle as rst is not accepted.
- WIDTH=1: all ops and reductions are still valid; red_or=red_and=red_xor=y.

Test Plan:
- WIDTH=8, out_ready=1, op=001, a=0x0F, b=0xF0 -> next cycle y=0xFF, out_valid=1, red_and=1, red_xor=0. Then the OR truth-table sweep on bit 0 (00,01,10,11) -> 0,1,1,1.
- All ops in turn with a=0xA5, b=0x3C -> AND 0x24, OR 0xBD, XOR 0x99, NAND 0xDB, NOR 0x42, XNOR 0x66, NOT 0x5A, PASS 0xA5.
- Backpressure: out_ready=0 after first result, in_valid held with a new beat -> in_ready=0, y stable for 5 cycles. Raise out_ready -> new result the next cycle, and no beat is lost or duplicated (beat_cnt matches).
- Accumulate: op=001, acc_en=1, beats a=0x01 (acc_clr=1), 0x04, 0x10 -> y=0x01, 0x05, 0x15. Then op=000 with acc_clr=1 a=0xFF, then a=0x0F -> y=0xFF, 0x0F.
- CNT_W=3: 10 back-to-back accepts -> beat_cnt saturates at 7.
- Assert rst while out_valid=1 and a beat is presented -> next cycle out_valid=0, y=0, beat_cnt=0. Then acc_en=1, acc_clr=0, op=001, a=0x02 -> y=0x02 (acc restarted from 0).
